// File: rtl/dot_row_acc_pkg.sv
// Shared constants for the multiplier-tree pipeline: default widths and the
// row-accumulator state encoding.
package dot_row_acc_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_LEN_WIDTH  = 16;

    localparam int unsigned STATE_WIDTH = 1;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_WIDTH-1:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through result FIFO with a registered head word and
// registered full/empty flags. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  do_push_c, do_pop_c;

    // Next pointers, occupancy, flags and the head word that will be visible next cycle.
    always_comb begin
        do_pop_c  = pop && !empty_q;
        do_push_c = push && (!full_q || do_pop_c);
        rptr_d    = rptr_q + AW'(do_pop_c);
        wptr_d    = wptr_q + AW'(do_push_c);
        cnt_d     = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
        full_d    = (cnt_d == CW'(FIFO_DEPTH));
        empty_d   = (cnt_d == CW'(0));
        rdata_d   = rdata_q;
        if (cnt_d != CW'(0)) begin
            // If nothing older survives this cycle, the new head is the word being pushed.
            if ((cnt_q - CW'(do_pop_c)) == CW'(0)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[rptr_d];
            end
        end
    end

    // Pointer, flag and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign rdata = rdata_q;

endmodule

// File: rtl/dot_row_acc.sv
// Row accumulator: sums per-cache-line partial dot products into one result
// per row and queues row results in a FWFT FIFO for the consumer.
module dot_row_acc
    import dot_row_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [LEN_WIDTH-1:0]  cfg_rows,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   line_q, line_d;
    logic [LEN_WIDTH-1:0]   row_q, row_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   rows_q, rows_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   push_c;
    logic                   pop_c;
    logic [DATA_WIDTH-1:0]  sum_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign pop_c = !fifo_empty && out_ready;
    assign sum_c = acc_q + in_data;

    // Next-state and datapath decisions for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        line_d  = line_q;
        row_d   = row_q;
        len_d   = len_q;
        rows_d  = rows_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                acc_d  = '0;
                line_d = '0;
                row_d  = '0;
                if (start) begin
                    state_d = ST_RUN;
                    len_d   = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
                    rows_d  = (cfg_rows == '0) ? LEN_WIDTH'(1) : cfg_rows;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (line_q == (len_q - LEN_WIDTH'(1))) begin
                        // Last line of the row: emit the row result and restart the sum.
                        push_c = 1'b1;
                        acc_d  = '0;
                        line_d = '0;
                        if (fifo_full && !pop_c) begin
                            ovf_d = 1'b1;
                        end
                        if (row_q == (rows_q - LEN_WIDTH'(1))) begin
                            done_d  = 1'b1;
                            row_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            row_d = row_q + LEN_WIDTH'(1);
                        end
                    end else begin
                        acc_d  = sum_c;
                        line_d = line_q + LEN_WIDTH'(1);
                    end
                end
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            line_q  <= '0;
            row_q   <= '0;
            len_q   <= '0;
            rows_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            line_q  <= line_d;
            row_q   <= row_d;
            len_q   <= len_d;
            rows_q  <= rows_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (sum_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (out_data)
    );

    assign out_valid = !fifo_empty;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_row_acc.sv
// Directed bench for dot_row_acc with a queue-based scoreboard: stimulus pushes
// expected row results, a monitor pops and compares on every output handshake.
module tb_dot_row_acc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_len;
    logic [15:0] cfg_rows;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned done_base;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic [31:0] held;

    dot_row_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_rows  (cfg_rows),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each accepted output word, and count done pulses.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", out_data, mon_exp);
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] rows);
        start    = 1'b1;
        cfg_len  = len;
        cfg_rows = rows;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        cfg_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Basic: two rows of four lines.
        out_ready = 1'b1;
        done_base = done_cnt;
        do_start(16'd4, 16'd2);
        check("basic_busy", 32'(busy), 32'd1);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd100);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        check("basic_done_row0", 32'(done), 32'd0);
        send(32'd10); send(32'd20); send(32'd30); send(32'd40);
        check("basic_done_pulse", 32'(done), 32'd1);
        tick(3);
        check("basic_done_count", done_cnt - done_base, 32'd1);
        check("basic_idle", 32'(busy), 32'd0);

        // Modular wrap of the accumulator.
        do_start(16'd2, 16'd1);
        exp_q.push_back(32'h0000_0001);
        send(32'hFFFF_FFFF); send(32'h0000_0002);
        tick(3);
        check("wrap_overflow", 32'(overflow), 32'd0);

        // Full FIFO: 5 and 6 are dropped.
        out_ready = 1'b0;
        done_base = done_cnt;
        do_start(16'd1, 16'd6);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back(32'(i));
            send(32'(i));
        end
        tick(2);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_done_count", done_cnt - done_base, 32'd1);
        check("full_head", out_data, 32'd1);
        held = out_data;
        tick(3);
        check("full_head_stable", out_data, held);
        out_ready = 1'b1;
        tick(6);
        check("full_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Push at full with a simultaneous pop; start also clears sticky overflow.
        do_start(16'd1, 16'd5);
        check("start_clears_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'd11 + 32'(i));
            send(32'd11 + 32'(i));
        end
        exp_q.push_back(32'd9);
        in_valid  = 1'b1;
        in_data   = 32'd9;
        out_ready = 1'b1;
        tick(1);
        in_valid  = 1'b0;
        tick(8);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_drained", 32'(out_valid), 32'd0);

        // Zero configuration acts as len=1, rows=1; IDLE ignores in_valid.
        do_start(16'd0, 16'd0);
        exp_q.push_back(32'd7);
        send(32'd7);
        check("zero_done", 32'(done), 32'd1);
        tick(1);
        check("zero_idle", 32'(busy), 32'd0);
        send(32'd55); send(32'd66);
        tick(3);
        check("idle_no_output", 32'(out_valid), 32'd0);

        // Reset mid-job discards FIFO contents and the partial row.
        out_ready = 1'b0;
        do_start(16'd4, 16'd2);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        send(32'd5); send(32'd6);
        check("prereset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        tick(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(32'd3);
        tick(2);
        check("post_reset_quiet", 32'(out_valid), 32'd0);
        do_start(16'd2, 16'd1);
        exp_q.push_back(32'd11);
        send(32'd5); send(32'd6);
        tick(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dot_row_acc.md
DOT_ROW_ACC -- requirements
Module: dot_row_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the partial-product input and the row result.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of result-FIFO entries (power of two, minimum 2).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the line-count and row-count configuration.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle pulse; latches cfg_len and cfg_rows and begins a job.
REQ-007 cfg_len  input  LEN_WIDTH  cache lines per row (value 0 treated as 1).
REQ-008 cfg_rows  input  LEN_WIDTH  rows per job (value 0 treated as 1).
REQ-009 in_valid  input  1  partial dot product valid; driven by the upstream multiplier-tree ready; no backpressure.
REQ-010 in_data  input  DATA_WIDTH  partial dot product of one cache line.
REQ-011 out_valid  output  1  FIFO head holds a row result.
REQ-012 out_data  output  DATA_WIDTH  row result at the FIFO head.
REQ-013 out_ready  input  1  consumer accepts the head when out_valid is high.
REQ-014 busy  output  1  high while in state RUN.
REQ-015 done  output  1  one-cycle pulse when the last row of a job is pushed.
REQ-016 overflow  output  1  sticky; set when a row result is dropped because the FIFO is full.

Function
REQ-017 SHALL implement the states IDLE and RUN only.
REQ-018 IDLE -> RUN on start; start in RUN SHALL be ignored.
REQ-019 In IDLE, in_valid SHALL be ignored; the accumulator, line counter and row counter are held at 0.
REQ-020 In RUN, each in_valid cycle SHALL add in_data to the accumulator modulo 2^DATA_WIDTH (no saturation) and increment the line counter.
REQ-021 On the in_valid cycle where the line counter equals len-1, SHALL push (acc + in_data) into the FIFO, clear the accumulator and the line counter to 0, and increment the row counter.
REQ-022 When the push in REQ-021 is for row rows-1, SHALL pulse done in the same cycle the push is registered and return to IDLE.
REQ-023 With len=1, every in_valid SHALL produce one push of in_data unchanged.
REQ-024 A push into an empty FIFO SHALL raise out_valid on the next cycle, with out_data equal to the pushed value; a pop SHALL occur on out_valid && out_ready.
REQ-025 A push when full without a simultaneous pop SHALL drop the value, set overflow, and still advance the counters and done.
REQ-026 A push when full with a simultaneous pop SHALL be accepted, with no overflow.
REQ-027 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 out_data SHALL hold stable while out_valid && !out_ready.
REQ-029 overflow SHALL clear only on reset or on a start accepted in IDLE.
REQ-030 FIFO contents SHALL persist across job boundaries; start SHALL not flush the FIFO.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE; accumulator, counters and FIFO pointers 0; out_valid=0, out_data=0, busy=0, done=0, overflow=0.
REQ-032 Reset mid-job SHALL discard the partial row and all FIFO contents; after release, nothing is output until the next start.

Structure
REQ-033 The state encoding (IDLE, RUN) and the default parameter constants SHALL be placed in a shared package for the multiplier-tree pipeline.
REQ-034 The result FIFO SHALL be a sub-module named sync_fifo_fwft (parameters DATA_WIDTH, FIFO_DEPTH; ports push, pop, full, empty).

Verification
REQ-035 Basic: len=4, rows=2, inputs 1,2,3,4,10,20,30,40, out_ready=1 -> outputs 10 then 100; done pulses once, with the second push.
REQ-036 Wrap: len=2, inputs 0xFFFFFFFF and 0x00000002 -> output 0x00000001, overflow stays 0.
REQ-037 Full FIFO: out_ready=0, len=1, rows=6, inputs 1..6 -> FIFO holds 1,2,3,4; 5 and 6 dropped; overflow=1; done pulses; draining yields 1,2,3,4.
REQ-038 Simultaneous push and pop at full: FIFO full, out_ready=1 in the same cycle as a push of 9 -> no overflow; 9 appears after the three remaining entries.
REQ-039 Configuration zero: cfg_len=0, cfg_rows=0, single input 7 -> output 7, done, return to IDLE; in_valid in IDLE produces no output.
REQ-040 Reset mid-job: rst_n low after 2 of 4 lines -> all outputs 0 immediately; new job len=2, inputs 5,6 -> output 11 only.
